universal_shift_register_seq: RTL and testbench

//  Parametrised universal shift register: parallel load, logical left/right

---
 rtl/shreg_pkg.sv | 21 ++
 rtl/shift_amount_counter.sv | 28 ++
 rtl/universal_shift_register_seq.sv | 132 +++++++++++++
 tb/tb_universal_shift_register_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: operation codes and FSM states.
// Mode codes not listed here decode as HOLD in the datapath.
package shreg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] HOLD = 3'd0;
  localparam logic [MODE_W-1:0] LOAD = 3'd1;
  localparam logic [MODE_W-1:0] SHL  = 3'd2;
  localparam logic [MODE_W-1:0] SHR  = 3'd3;
  localparam logic [MODE_W-1:0] ASR  = 3'd4;
  localparam logic [MODE_W-1:0] ROTL = 3'd5;
  localparam logic [MODE_W-1:0] ROTR = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_amount_counter.sv
// Remaining-shift counter: loads the requested amount, decrements once per shift.
// Latency: load/decrement visible one edge later; is_one is combinational from the count.
module shift_amount_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] amount,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= amount;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/universal_shift_register_seq.sv
// Universal shift register, one bit per clock; rotate ops exist only with USR_ROTATE_EN.
// Latency: LOAD/HOLD done one cycle after start, N shifts done N+1 cycles after start.
// Backpressure: start is accepted only in IDLE; starts while busy or done are dropped.
module universal_shift_register_seq
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [CNT_W-1:0]  amount,
  input  logic [WIDTH-1:0]  D,
  input  logic              sin,
  output logic [WIDTH-1:0]  Q,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_q;
  logic              shift_op;
  logic              cnt_load, cnt_dec, cnt_is_one;

  // Only modes that really move bits enter SHIFT; everything else behaves as HOLD.
  always_comb begin
    shift_op = 1'b0;
    case (mode)
      SHL, SHR, ASR: shift_op = 1'b1;
`ifdef USR_ROTATE_EN
      ROTL, ROTR:    shift_op = 1'b1;
`endif
      default:       shift_op = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (shift_op && (amount != '0)) begin
            state_d  = SHIFT;
            cnt_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_is_one) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  shift_amount_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clk    (Clk),
    .reset  (reset),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .amount (amount),
    .is_one (cnt_is_one)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      mode_q <= HOLD;
    end else if ((state_q == IDLE) && start) begin
      mode_q <= mode;
    end
  end

  // sin stays live during SHIFT; only the operation itself is latched.
  always_ff @(posedge Clk) begin
    if (reset) begin
      Q    <= '0;
      sout <= 1'b0;
    end else if ((state_q == IDLE) && start && (mode == LOAD)) begin
      Q <= D;
    end else if (state_q == SHIFT) begin
      case (mode_q)
        SHL: begin
          Q    <= {Q[WIDTH-2:0], sin};
          sout <= Q[WIDTH-1];
        end
        SHR: begin
          Q    <= {sin, Q[WIDTH-1:1]};
          sout <= Q[0];
        end
        ASR: begin
          Q    <= {Q[WIDTH-1], Q[WIDTH-1:1]};
          sout <= Q[0];
        end
`ifdef USR_ROTATE_EN
        ROTL: begin
          Q    <= {Q[WIDTH-2:0], Q[WIDTH-1]};
          sout <= Q[WIDTH-1];
        end
        ROTR: begin
          Q    <= {Q[0], Q[WIDTH-1:1]};
          sout <= Q[0];
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Directed bench for universal_shift_register_seq at WIDTH=8; expected values are hand-computed.
module tb_universal_shift_register_seq;
  import shreg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic              Clk = 1'b0;
  logic              reset;
  logic              start;
  logic [MODE_W-1:0] mode;
  logic [CNT_W-1:0]  amount;
  logic [WIDTH-1:0]  D;
  logic              sin;
  logic [WIDTH-1:0]  Q;
  logic              sout;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_register_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk    (Clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .D      (D),
    .sin    (sin),
    .Q      (Q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [MODE_W-1:0] m, input logic [CNT_W-1:0] a,
                          input logic [WIDTH-1:0] d);
    mode   = m;
    amount = a;
    D      = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = HOLD; amount = '0; D = '0; sin = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_q", Q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sout", sout, 1'b0);

    // 1: reset in the middle of an SHL by 5
    do_start(LOAD, 4'd0, 8'h81);
    tick();
    do_start(SHL, 4'd5, 8'h00);
    tick();
    tick();
    check("t1_mid_busy", busy, 1'b1);
    check("t1_mid_q", Q, 8'h04);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("t1_q", Q, 8'h00);
    check("t1_busy", busy, 1'b0);
    check("t1_done", done, 1'b0);
    tick();
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_done", done, 1'b0);

    // 2: parallel load
    do_start(LOAD, 4'd3, 8'hA5);
    check("t2_q", Q, 8'hA5);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    tick();
    check("t2_done_off", done, 1'b0);

    // 3: SHL by 3 with sin=1
    do_start(LOAD, 4'd0, 8'h81);
    tick();
    sin = 1'b1;
    do_start(SHL, 4'd3, 8'h00);
    check("t3_busy0", busy, 1'b1);
    check("t3_q0", Q, 8'h81);
    tick();
    check("t3_busy1", busy, 1'b1);
    check("t3_q1", Q, 8'h03);
    check("t3_sout1", sout, 1'b1);
    tick();
    check("t3_busy2", busy, 1'b1);
    check("t3_q2", Q, 8'h07);
    tick();
    check("t3_q", Q, 8'h0F);
    check("t3_sout", sout, 1'b0);
    check("t3_done", done, 1'b1);
    check("t3_busy_off", busy, 1'b0);
    tick();
    check("t3_done_off", done, 1'b0);
    sin = 1'b0;

    // 4: ASR by 2, then ASR by 0
    do_start(LOAD, 4'd0, 8'h90);
    tick();
    do_start(ASR, 4'd2, 8'h00);
    tick();
    check("t4_q1", Q, 8'hC8);
    tick();
    check("t4_q", Q, 8'hE4);
    check("t4_sout", sout, 1'b0);
    check("t4_done", done, 1'b1);
    tick();
    do_start(ASR, 4'd0, 8'h00);
    check("t4_zero_done", done, 1'b1);
    check("t4_zero_busy", busy, 1'b0);
    check("t4_zero_q", Q, 8'hE4);
    tick();

    // 5: ROTR by 1
    do_start(LOAD, 4'd0, 8'h81);
    tick();
    do_start(ROTR, 4'd1, 8'h00);
`ifdef USR_ROTATE_EN
    check("t5_busy", busy, 1'b1);
    tick();
    check("t5_q", Q, 8'hC0);
    check("t5_sout", sout, 1'b1);
    check("t5_done", done, 1'b1);
`else
    check("t5_busy", busy, 1'b0);
    check("t5_q", Q, 8'h81);
    check("t5_done", done, 1'b1);
`endif
    tick();

    // 6: starts during SHIFT and DONE are dropped, next IDLE start is taken
    do_start(LOAD, 4'd0, 8'hF0);
    tick();
    sin = 1'b0;
    do_start(SHR, 4'd4, 8'h00);
    mode = LOAD; D = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_shift_ign_q", Q, 8'h78);
    check("t6_shift_ign_busy", busy, 1'b1);
    tick();
    tick();
    tick();
    check("t6_q", Q, 8'h0F);
    check("t6_done", done, 1'b1);
    mode = LOAD; D = 8'h55; start = 1'b1;
    tick();
    check("t6_done_ign_q", Q, 8'h0F);
    check("t6_done_ign_done", done, 1'b0);
    tick();
    start = 1'b0;
    check("t6_accept_q", Q, 8'h55);
    check("t6_accept_done", done, 1'b1);
    tick();

    // amount larger than WIDTH: only sin history remains
    sin = 1'b1;
    do_start(SHL, 4'd9, 8'h00);
    repeat (8) tick();
    check("big_busy", busy, 1'b1);
    tick();
    check("big_q", Q, 8'hFF);
    check("big_done", done, 1'b1);
    tick();
    check("big_done_off", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
